// File: rtl/aes_pkg.sv
`default_nettype none
//============================================================================
// Package : aes_pkg
// Shared AES constants: forward S-box, GF(2^8) helpers and cipher FSM states.
// Revision: 1.0
//============================================================================
package aes_pkg;

    localparam int Nb = 4;

    // Entry 0 sits in the most significant byte of the packed table.
    localparam logic [0:255][7:0] c_sbox_table = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return c_sbox_table[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round.sv
`default_nettype none
//============================================================================
// Module : aes_round
// One combinational forward AES round: SubBytes, ShiftRows, MixColumns, ARK.
// Revision: 1.0
//============================================================================
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] st_in,
    input  logic [127:0] rk,
    input  logic         final_rnd,
    output logic [127:0] st_out
);

    // Byte n of the state is row n%4, column n/4; byte 0 is the MSB.
    logic [0:15][7:0] w_in;
    logic [0:15][7:0] w_sb;
    logic [0:15][7:0] w_sr;
    logic [0:15][7:0] w_mc;

    assign w_in = st_in;

    always_comb begin
        w_sb = '0;
        w_sr = '0;
        w_mc = '0;
        for (int n = 0; n < 16; n++) begin
            w_sb[n] = sbox(w_in[n]);
        end
        // Row r rotates left by r columns.
        for (int c = 0; c < Nb; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_sr[4*c + r] = w_sb[4*((c + r) % Nb) + r];
            end
        end
        for (int c = 0; c < Nb; c++) begin
            w_mc[4*c + 0] = gmul2(w_sr[4*c]) ^ gmul3(w_sr[4*c + 1]) ^ w_sr[4*c + 2] ^ w_sr[4*c + 3];
            w_mc[4*c + 1] = w_sr[4*c] ^ gmul2(w_sr[4*c + 1]) ^ gmul3(w_sr[4*c + 2]) ^ w_sr[4*c + 3];
            w_mc[4*c + 2] = w_sr[4*c] ^ w_sr[4*c + 1] ^ gmul2(w_sr[4*c + 2]) ^ gmul3(w_sr[4*c + 3]);
            w_mc[4*c + 3] = gmul3(w_sr[4*c]) ^ w_sr[4*c + 1] ^ w_sr[4*c + 2] ^ gmul2(w_sr[4*c + 3]);
        end
    end

    assign st_out = (final_rnd ? w_sr : w_mc) ^ rk;

endmodule
`default_nettype wire

// File: rtl/aes_cipher_iter.sv
`default_nettype none
//============================================================================
// Module : aes_cipher_iter
// Iterative AES forward cipher, one round per clock, valid/ready handshakes.
// Revision: 1.0
//============================================================================
module aes_cipher_iter
    import aes_pkg::*;
#(
    parameter int Nk = 4,
    parameter int Nr = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in,
    input  logic [0:Nr][127:0] k_sch,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out
);

    if (Nr != Nk + 6) begin : g_bad_nr
        $error("aes_cipher_iter: Nr (%0d) must equal Nk+6 (%0d)", Nr, Nk + 6);
    end
    if (Nk != 4 && Nk != 6 && Nk != 8) begin : g_bad_nk
        $error("aes_cipher_iter: Nk (%0d) must be 4, 6 or 8", Nk);
    end

    localparam int                 c_rnd_w     = $clog2(Nr + 1);
    localparam logic [c_rnd_w-1:0] c_rnd_first = c_rnd_w'(1);
    localparam logic [c_rnd_w-1:0] c_rnd_last  = c_rnd_w'(Nr);

    aes_state_e         r_state;
    aes_state_e         w_state_nxt;
    logic [127:0]       r_st;
    logic [c_rnd_w-1:0] r_rnd;
    logic               r_out_valid;
    logic               w_load;
    logic               w_step;
    logic               w_final;
    logic [127:0]       w_rk;
    logic [127:0]       w_round_out;

    assign w_final = (r_rnd == c_rnd_last);

    always_comb begin
        w_rk = '0;
        if (r_rnd <= c_rnd_last) begin
            w_rk = k_sch[r_rnd];
        end
    end

    aes_round u_round (
        .st_in     (r_st),
        .rk        (w_rk),
        .final_rnd (w_final),
        .st_out    (w_round_out)
    );

    // In DONE the consumer's ready doubles as our ready so a new block can be
    // taken in the same cycle the finished one leaves.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        in_ready    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_rnd == '0 || r_rnd > c_rnd_last) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_step = 1'b1;
                    if (w_final) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        w_load      = 1'b1;
                        w_state_nxt = RUN;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_st        <= '0;
            r_rnd       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_out_valid <= (w_state_nxt == DONE);
            if (w_load) begin
                r_st  <= in ^ k_sch[0];
                r_rnd <= c_rnd_first;
            end else if (w_step) begin
                r_st <= w_round_out;
                if (!w_final) begin
                    r_rnd <= r_rnd + 1'b1;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out       = r_st;

endmodule
`default_nettype wire

// File: tb/tb_aes_cipher_iter.sv
`default_nettype none
//============================================================================
// Module : tb_aes_cipher_iter
// Scoreboard bench for aes_cipher_iter: FIPS-197 vectors plus random blocks.
// Revision: 1.0
//============================================================================
module tb_aes_cipher_iter;

    typedef logic [0:14][127:0] rks_t;
    typedef struct {
        logic [127:0] pt;
        logic [127:0] ct;
        bit           has_ct;
        rks_t         rk;
        int           nr;
    } exp_t;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic              a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [127:0]      a_in, a_out;
    logic [0:10][127:0] a_ksch;
    logic              b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [127:0]      b_in, b_out;
    logic [0:14][127:0] b_ksch;

    logic rand_mode, dir_rdy, rnd_rdy;
    assign a_out_ready = rand_mode ? rnd_rdy : dir_rdy;

    aes_cipher_iter #(.Nk(4), .Nr(10)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in(a_in), .k_sch(a_ksch),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out(a_out)
    );

    aes_cipher_iter #(.Nk(8), .Nr(14)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in(b_in), .k_sch(b_ksch),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out(b_out)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t a_q[$];
    exp_t b_q[$];
    logic [7:0] tb_sbox [256];
    logic [7:0] tb_isbox [256];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no event within budget, required event", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box built from its definition: GF(2^8) inverse then affine transform.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            tb_sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) tb_isbox[tb_sbox[x]] = 8'(x);
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {tb_sbox[w[31:24]], tb_sbox[w[23:16]], tb_sbox[w[15:8]], tb_sbox[w[7:0]]};
    endfunction

    function automatic rks_t key_expand(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rks_t        rk;
        int          nr;
        nr = nk + 6; rc = 8'h01; rk = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        return rk;
    endfunction

    function automatic logic [127:0] inv_cipher(input logic [127:0] ct, input rks_t rk, input int nr);
        logic [127:0] x;
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        x = ct ^ rk[nr];
        for (int r = nr - 1; r >= 0; r--) begin
            for (int i = 0; i < 16; i++) s[i] = x[127-8*i -: 8];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4*c+row] = tb_isbox[s[4*((c - row + 4) % 4) + row]];
            for (int i = 0; i < 16; i++) x[127-8*i -: 8] = t[i];
            x = x ^ rk[r];
            if (r > 0) begin
                for (int i = 0; i < 16; i++) t[i] = x[127-8*i -: 8];
                for (int c = 0; c < 4; c++) begin
                    s[4*c+0] = gm(t[4*c], 8'h0e) ^ gm(t[4*c+1], 8'h0b) ^ gm(t[4*c+2], 8'h0d) ^ gm(t[4*c+3], 8'h09);
                    s[4*c+1] = gm(t[4*c], 8'h09) ^ gm(t[4*c+1], 8'h0e) ^ gm(t[4*c+2], 8'h0b) ^ gm(t[4*c+3], 8'h0d);
                    s[4*c+2] = gm(t[4*c], 8'h0d) ^ gm(t[4*c+1], 8'h09) ^ gm(t[4*c+2], 8'h0e) ^ gm(t[4*c+3], 8'h0b);
                    s[4*c+3] = gm(t[4*c], 8'h0b) ^ gm(t[4*c+1], 8'h0d) ^ gm(t[4*c+2], 8'h09) ^ gm(t[4*c+3], 8'h0e);
                end
                for (int i = 0; i < 16; i++) x[127-8*i -: 8] = s[i];
            end
        end
        return x;
    endfunction

    task automatic a_load_key(input rks_t rks);
        for (int r = 0; r <= 10; r++) a_ksch[r] = rks[r];
    endtask

    task automatic a_offer(input logic [127:0] pt, input string name, output bit ok);
        a_in = pt; a_in_valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (a_in_ready) begin
                ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        a_in_valid = 1'b0;
        if (!ok) fail_timeout({name, "_accept"});
    endtask

    // Called one cycle after accept; also holds in_valid during RUN, which must be ignored.
    task automatic a_wait_out(input string name, input int exp_lat);
        int n;
        n = 0;
        while (!a_out_valid && n < 40) begin
            a_in_valid = (n >= 1 && n <= 3);
            if (n == 2) check({name, "_run_in_ready"}, a_in_ready, 0);
            tick();
            n++;
        end
        a_in_valid = 1'b0;
        if (!a_out_valid) fail_timeout({name, "_out_valid"});
        else check({name, "_latency"}, n, exp_lat);
    endtask

    task automatic a_block(input logic [127:0] key, input logic [127:0] pt,
                           input logic [127:0] ct, input string name);
        rks_t rks;
        bit   ok;
        rks = key_expand({key, 128'h0}, 4);
        a_load_key(rks);
        a_q.push_back('{pt, ct, 1'b1, rks, 10});
        a_offer(pt, name, ok);
        if (ok) a_wait_out(name, 10);
    endtask

    // Monitors: pop the scoreboard on every output handshake.
    exp_t a_e, b_e;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && a_out_valid && a_out_ready) begin
                if (a_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected: got output %h, required none", a_out);
                end else begin
                    a_e = a_q.pop_front();
                    if (a_e.has_ct) check("a_ct", a_out, a_e.ct);
                    check("a_decrypt", inv_cipher(a_out, a_e.rk, a_e.nr), a_e.pt);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && b_out_valid && b_out_ready) begin
                if (b_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected: got output %h, required none", b_out);
                end else begin
                    b_e = b_q.pop_front();
                    if (b_e.has_ct) check("b_ct", b_out, b_e.ct);
                    check("b_decrypt", inv_cipher(b_out, b_e.rk, b_e.nr), b_e.pt);
                end
            end
        end
    end

    initial begin
        rnd_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rnd_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        rks_t         rks;
        bit           ok;
        int           n;
        logic [127:0] key, pt;

        rst = 1'b1; rand_mode = 1'b0; dir_rdy = 1'b1;
        a_in_valid = 1'b0; a_in = '0; a_ksch = '0;
        b_in_valid = 1'b0; b_in = '0; b_ksch = '0; b_out_ready = 1'b1;
        build_sbox();
        repeat (3) tick();

        check("rst_a_in_ready", a_in_ready, 1);
        check("rst_a_out_valid", a_out_valid, 0);
        check("rst_a_out", a_out, 0);
        check("rst_b_in_ready", b_in_ready, 1);
        check("rst_b_out_valid", b_out_valid, 0);
        rst = 1'b0;
        tick();

        a_block(C1_KEY, C1_PT, C1_CT, "c1");
        tick();
        a_block(B_KEY, B_PT, B_CT, "appb");
        tick();

        // Backpressure, then consume and accept in the same cycle.
        dir_rdy = 1'b0;
        a_block(C1_KEY, C1_PT, C1_CT, "bp");
        for (int k = 0; k < 5; k++) begin
            check("bp_out_stable", a_out, C1_CT);
            check("bp_stall_in_ready", a_in_ready, 0);
            tick();
        end
        rks = key_expand({B_KEY, 128'h0}, 4);
        a_load_key(rks);
        a_q.push_back('{B_PT, B_CT, 1'b1, rks, 10});
        a_in = B_PT; a_in_valid = 1'b1; dir_rdy = 1'b1;
        @(negedge clk);
        check("bp_overlap_in_ready", a_in_ready, 1);
        tick();
        a_in_valid = 1'b0;
        check("bp_overlap_out_valid", a_out_valid, 0);
        a_wait_out("bp_second", 10);
        tick();

        // Reset in the middle of a block discards it.
        rks = key_expand({C1_KEY, 128'h0}, 4);
        a_load_key(rks);
        a_offer(C1_PT, "rst_mid", ok);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_out_valid", a_out_valid, 0);
        check("rst_mid_out", a_out, 0);
        check("rst_mid_in_ready", a_in_ready, 1);
        a_block(C1_KEY, C1_PT, C1_CT, "c1_after_rst");
        tick();

        // AES-256 instance.
        rks = key_expand(C3_KEY, 8);
        b_ksch = rks;
        b_q.push_back('{C1_PT, C3_CT, 1'b1, rks, 14});
        b_in = C1_PT; b_in_valid = 1'b1;
        check("b_in_ready_idle", b_in_ready, 1);
        tick();
        b_in_valid = 1'b0;
        n = 0;
        while (!b_out_valid && n < 40) begin tick(); n++; end
        if (!b_out_valid) fail_timeout("b_out_valid");
        else check("b_latency", n, 14);
        tick();

        // Closed loop with random keys and consumer stalls.
        rand_mode = 1'b1;
        for (int i = 0; i < 100; i++) begin
            n = 0;
            while (a_q.size() != 0 && n < 200) begin tick(); n++; end
            if (a_q.size() != 0) begin fail_timeout("rand_drain"); break; end
            repeat ($urandom_range(0, 3)) tick();
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            rks = key_expand({key, 128'h0}, 4);
            a_load_key(rks);
            a_q.push_back('{pt, 128'h0, 1'b0, rks, 10});
            a_offer(pt, "rand", ok);
        end
        n = 0;
        while (a_q.size() != 0 && n < 200) begin tick(); n++; end
        rand_mode = 1'b0;
        repeat (3) tick();

        check("a_scoreboard_empty", a_q.size(), 0);
        check("b_scoreboard_empty", b_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
